// File: rtl/graph_ram_scheduler.sv
// graph_ram_scheduler: clears, erases and plots the 1-bit speed-graph frame RAM,
// handing the RAM port to the VGA scan whenever it is reading.
module graph_ram_scheduler #(
    parameter int WIDTH  = 300,
    parameter int HEIGHT = 100,
    parameter int ADDR_W = 15
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_sample_valid,
    input  logic [15:0]       i_sample_value,
    output logic              o_sample_ready,
    output logic              o_overrun,
    output logic [ADDR_W-1:0] o_column,
    input  logic              i_vga_active,
    input  logic [ADDR_W-1:0] i_vga_addr,
    output logic              o_vga_pixel,
    output logic [ADDR_W-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic              o_ram_din,
    input  logic              i_ram_dout
);
    typedef enum logic [1:0] {INIT, IDLE, ERASE, PLOT} state_t;
    localparam logic [ADDR_W-1:0] A_ONE   = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] A_LAST  = ADDR_W'(WIDTH * HEIGHT - 1);
    localparam logic [ADDR_W-1:0] A_WIDTH = ADDR_W'(WIDTH);
    localparam logic [ADDR_W-1:0] A_WLAST = ADDR_W'(WIDTH - 1);
    localparam logic [ADDR_W-1:0] A_HLAST = ADDR_W'(HEIGHT - 1);
    localparam logic [15:0]       V_HLAST = 16'(HEIGHT - 1);
    state_t            r_state;
    logic [ADDR_W-1:0] r_col;
    logic [ADDR_W-1:0] r_row;
    logic [ADDR_W-1:0] r_row_base;
    logic [ADDR_W-1:0] r_target;
    logic [ADDR_W-1:0] r_plot_base;
    logic              r_overrun;
    logic              r_rd_q;
    logic              r_pixel;
    logic              w_slot;
    logic [ADDR_W-1:0] w_waddr;
    // INIT walks row_base linearly over the whole frame; ERASE steps it by WIDTH
    assign w_slot  = i_rst_n && !i_vga_active && (r_state != IDLE);
    assign w_waddr = (r_state == PLOT ? r_plot_base : r_row_base) + (r_state == INIT ? '0 : r_col);
    assign o_ram_we       = w_slot;
    assign o_ram_addr     = !i_rst_n ? '0 : i_vga_active ? i_vga_addr : w_waddr;
    assign o_ram_din      = (r_state == PLOT);
    assign o_sample_ready = (r_state == IDLE);
    assign o_overrun      = r_overrun;
    assign o_column       = r_col;
    assign o_vga_pixel    = r_pixel;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= INIT;
            r_col       <= '0;
            r_row       <= '0;
            r_row_base  <= '0;
            r_target    <= '0;
            r_plot_base <= '0;
            r_overrun   <= 1'b0;
            r_rd_q      <= 1'b0;
            r_pixel     <= 1'b0;
        end else begin
            r_overrun <= i_sample_valid && (r_state != IDLE);
            r_rd_q    <= i_vga_active;
            r_pixel   <= i_ram_dout && r_rd_q;
            unique case (r_state)
                INIT: if (w_slot) begin
                    r_row_base <= (r_row_base == A_LAST) ? '0 : r_row_base + A_ONE;
                    if (r_row_base == A_LAST) r_state <= IDLE;
                end
                IDLE: if (i_sample_valid) begin
                    r_target   <= ADDR_W'(V_HLAST - (i_sample_value > V_HLAST ? V_HLAST : i_sample_value));
                    r_row      <= '0;
                    r_row_base <= '0;
                    r_state    <= ERASE;
                end
                // the erase sweep passes the target row, so its base is captured on the way
                ERASE: if (w_slot) begin
                    if (r_row == r_target) r_plot_base <= r_row_base;
                    r_row      <= r_row + A_ONE;
                    r_row_base <= r_row_base + A_WIDTH;
                    if (r_row == A_HLAST) r_state <= PLOT;
                end
                PLOT: if (w_slot) begin
                    r_col   <= (r_col == A_WLAST) ? '0 : r_col + A_ONE;
                    r_state <= IDLE;
                end
                default: r_state <= INIT;
            endcase
        end
    end
endmodule

// File: tb/tb_graph_ram_scheduler.sv
// tb_graph_ram_scheduler: random samples and VGA traffic against a model of the
// expected RAM write sequence, column and read pipeline.
module tb_graph_ram_scheduler;
    localparam int W = 300;
    localparam int H = 100;
    localparam int N = W * H;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid = 1'b0;
    logic [15:0] value = '0;
    logic        vga = 1'b0;
    logic [14:0] vga_addr = '0;
    logic        ready;
    logic        overrun;
    logic [14:0] column;
    logic        pixel;
    logic [14:0] ram_addr;
    logic        ram_we;
    logic        ram_din;
    logic        ram_dout = 1'b0;
    logic        preset = 1'b0;
    bit          mem [N];
    int          wr_cnt = 0;
    int          last_wr = 0;
    int          last_plot = 0;
    int          checks = 0;
    int          failures = 0;
    int          q[$];
    int          m_init = 0;
    int          m_col = 0;
    int          m_e;
    int          m_t;
    bit          m_rdy;
    bit          m_ovr = 1'b0;
    bit          m_pix = 1'b0;
    bit          m_rd = 1'b0;
    int          ovr_cnt = 0;

    always #5 clk = ~clk;

    graph_ram_scheduler dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_sample_valid(valid), .i_sample_value(value),
        .o_sample_ready(ready), .o_overrun(overrun), .o_column(column),
        .i_vga_active(vga), .i_vga_addr(vga_addr), .o_vga_pixel(pixel),
        .o_ram_addr(ram_addr), .o_ram_we(ram_we), .o_ram_din(ram_din), .i_ram_dout(ram_dout)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        ram_dout <= (ram_addr < 15'(N)) ? mem[ram_addr] : 1'b0;
        if (preset) for (int i = 0; i < N; i++) mem[i] <= 1'($urandom);
        if (!rst_n) wr_cnt <= 0;
        else if (ram_we && ram_addr < 15'(N)) begin
            mem[ram_addr] <= ram_din;
            wr_cnt <= wr_cnt + 1;
            last_wr <= int'(ram_addr);
            if (ram_din) last_plot <= int'(ram_addr);
        end
    end

    // model: a pending write list (frame clear, then per sample 100 erases + 1 plot)
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_ready", int'(ready), 0);
            chk("rst_overrun", int'(overrun), 0);
            chk("rst_pixel", int'(pixel), 0);
            chk("rst_we", int'(ram_we), 0);
            chk("rst_din", int'(ram_din), 0);
            chk("rst_addr", int'(ram_addr), 0);
            chk("rst_column", int'(column), 0);
            q.delete();
            m_init = 0;
            m_col = 0;
            m_ovr = 1'b0;
            m_pix = 1'b0;
            m_rd = 1'b0;
        end else begin
            m_rdy = (m_init == N) && (q.size() == 0);
            chk("ready", int'(ready), int'(m_rdy));
            chk("overrun", int'(overrun), int'(m_ovr));
            chk("column", int'(column), m_col);
            chk("pixel", int'(pixel), int'(m_pix));
            ovr_cnt += int'(overrun);
            if (vga) begin
                chk("vga_we", int'(ram_we), 0);
                chk("vga_addr", int'(ram_addr), int'(vga_addr));
            end else if (!m_rdy) begin
                m_e = (m_init < N) ? m_init * 2 : q[0];
                chk("we", int'(ram_we), 1);
                chk("waddr", int'(ram_addr), m_e / 2);
                chk("wdata", int'(ram_din), m_e % 2);
                if (m_init < N) m_init++;
                else begin
                    void'(q.pop_front());
                    if (m_e % 2 == 1) m_col = (m_col + 1) % W;
                end
            end else chk("idle_we", int'(ram_we), 0);
            m_pix = m_rd;
            m_rd = vga && mem[vga_addr];
            m_ovr = valid && !m_rdy;
            if (valid && m_rdy) begin
                m_t = H - 1 - ((int'(value) > H - 1) ? H - 1 : int'(value));
                for (int r = 0; r < H; r++) q.push_back((r * W + m_col) * 2);
                q.push_back((m_t * W + m_col) * 2 + 1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) begin
            vga = 1'($urandom_range(0, 1));
            vga_addr = 15'($urandom_range(0, N - 1));
            step();
        end
        vga = 1'b0;
    endtask

    // mode 0: no VGA, 1: VGA toggles every 4 cycles, 2: random VGA, 3: extra sample mid-erase
    task automatic run_sample(input int v, input int mode, output int lat);
        valid = 1'b1;
        value = 16'(v);
        vga = (mode == 1) || (mode == 2 && $urandom_range(0, 1) == 1);
        vga_addr = 15'($urandom_range(0, N - 1));
        step();
        valid = 1'b0;
        lat = 0;
        while (!ready && lat < 2000) begin
            vga = mode == 1 ? (((lat + 1) / 4) % 2 == 0) : mode == 2 ? 1'($urandom_range(0, 1)) : 1'b0;
            vga_addr = 15'($urandom_range(0, N - 1));
            valid = (mode == 3 && lat == 20);
            value = 16'($urandom);
            step();
            valid = 1'b0;
            lat++;
        end
        vga = 1'b0;
        if (lat >= 2000) chk("sample_timeout", lat, 0);
    endtask

    initial begin
        int lat, n, a, o0;
        repeat (3) step();
        rst_n = 1'b1;
        n = 0;
        while (!ready && n < 31000) begin
            step();
            n++;
        end
        chk("init_cycles", n, N);
        chk("init_writes", wr_cnt, N);
        chk("init_last", last_wr, N - 1);
        preset = 1'b1;
        step();
        preset = 1'b0;
        a = 0;
        while (a < N - 1 && !mem[a]) a++;
        vga = 1'b1;
        vga_addr = 15'(a);
        step();
        vga = 1'b0;
        chk("rd_lat1", int'(pixel), 0);
        step();
        chk("rd_lat2", int'(pixel), int'(mem[a]));
        step();
        chk("rd_lat3", int'(pixel), 0);
        run_sample(40, 0, lat);
        chk("s40_latency", lat, 101);
        chk("s40_plot", last_plot, 17700);
        chk("s40_column", int'(column), 1);
        gap();
        run_sample($urandom_range(0, 99), 1, lat);
        chk("toggle_column", int'(column), 2);
        gap();
        o0 = ovr_cnt;
        run_sample(10, 3, lat);
        chk("ovr_pulses", ovr_cnt - o0, 1);
        chk("ovr_plot", last_plot, 89 * W + 2);
        chk("ovr_column", int'(column), 3);
        n = 0;
        while (m_col != W - 1 && n < 400) begin
            gap();
            run_sample($urandom_range(0, 250), n < 8 ? 2 : 0, lat);
            n++;
        end
        run_sample(500, 0, lat);
        chk("clamp_plot", last_plot, 299);
        chk("clamp_latency", lat, 101);
        chk("wrap_column", int'(column), 0);
        valid = 1'b1;
        value = 16'd70;
        step();
        valid = 1'b0;
        repeat (50) step();
        rst_n = 1'b0;
        #1;
        chk("abort_we", int'(ram_we), 0);
        chk("abort_ready", int'(ready), 0);
        chk("abort_addr", int'(ram_addr), 0);
        chk("abort_row49", last_wr, 49 * W);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (200) step();
        chk("reinit_writes", wr_cnt, 200);
        chk("reinit_last", last_wr, 199);
        chk("reinit_column", int'(column), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
